// File: rtl/alu_seq_ctrl_if.sv
// rtl/alu_seq_ctrl_if.sv - request, ALU-side and response bundle for alu_seq_ctrl
//
// Purpose: groups the two request ports, the ALU drive/return signals and the
// response channel into one bundle.
//   slave  : seen by the sequencer (alu_seq_ctrl)
//   master : seen by the environment (requesters, ALU, response consumer)
// Signals:
//   req0_*/req1_*  : valid/ready request with a, b, op, pc
//   flush          : abort in-flight or pending operation
//   alu_a/b/pc/op  : registered operands to the ALU, alu_tick = ALU load pulse
//   alu_*_in       : result, zero, overflow, branch_taken returned by the ALU
//   rsp_*          : captured response, valid/ready handshake, rsp_id = port
//   busy           : sequencer not idle
interface alu_seq_ctrl_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic [4:0]  req0_op;
  logic [31:0] req0_pc;

  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic [4:0]  req1_op;
  logic [31:0] req1_pc;

  logic        flush;

  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_pc;
  logic [4:0]  alu_op;
  logic        alu_tick;

  logic [31:0] alu_result_in;
  logic        alu_zero_in;
  logic        alu_overflow_in;
  logic [2:0]  alu_branch_in;

  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_result;
  logic        rsp_zero;
  logic        rsp_overflow;
  logic [2:0]  rsp_branch;

  logic        busy;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op, req0_pc,
    input  req1_valid, req1_a, req1_b, req1_op, req1_pc,
    input  flush,
    input  alu_result_in, alu_zero_in, alu_overflow_in, alu_branch_in,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output alu_a, alu_b, alu_pc, alu_op, alu_tick,
    output rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_overflow, rsp_branch,
    output busy
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op, req0_pc,
    output req1_valid, req1_a, req1_b, req1_op, req1_pc,
    output flush,
    output alu_result_in, alu_zero_in, alu_overflow_in, alu_branch_in,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  alu_a, alu_b, alu_pc, alu_op, alu_tick,
    input  rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_overflow, rsp_branch,
    input  busy
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - round-robin two-port sequencer for the multi-cycle ALU
//
// Purpose: arbitrates two requesters (port 0 = ID/EX, port 1 = aux/debug),
// issues the winner to the registered ALU with a one-cycle alu_tick, waits
// SETTLE_CYCLES edges, then holds the captured result in a response register
// until rsp_ready.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : alu_seq_ctrl_if.slave (requests, ALU drive/return, response, busy)
// Parameter:
//   SETTLE_CYCLES : edges after the tick edge until ALU outputs are valid (1..15)
// Build option:
//   ALU_SEQ_FASTPATH_EN : non-branch ops capture one cycle early and report
//                         rsp_branch = 0
module alu_seq_ctrl #(
  parameter int SETTLE_CYCLES = 3
) (
  input  logic          clk,
  input  logic          rst,
  alu_seq_ctrl_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [3:0] SETTLE = 4'(SETTLE_CYCLES);

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic        last_grant;

  logic [31:0] alu_a_q;
  logic [31:0] alu_b_q;
  logic [31:0] alu_pc_q;
  logic [4:0]  alu_op_q;

  logic        rsp_id_q;
  logic [31:0] rsp_result_q;
  logic        rsp_zero_q;
  logic        rsp_overflow_q;
  logic [2:0]  rsp_branch_q;

  logic        grant0;
  logic        grant1;
  logic        ready0;
  logic        ready1;
  logic        fire0;
  logic        fire1;
  logic        capture;
  logic        fast_op;

  // Round-robin: a lone requester always wins; on contention the port that
  // was not granted last wins.
  assign grant0 = bus.req0_valid && (!bus.req1_valid || last_grant);
  assign grant1 = bus.req1_valid && (!bus.req0_valid || !last_grant);

  // Ready is held low while rst is asserted so every output reads 0 in reset.
  assign ready0 = !rst && (state == S_IDLE) && grant0 && !bus.flush;
  assign ready1 = !rst && (state == S_IDLE) && grant1 && !bus.flush;
  assign fire0  = bus.req0_valid && ready0;
  assign fire1  = bus.req1_valid && ready1;

`ifdef ALU_SEQ_FASTPATH_EN
  function automatic logic is_branch(input logic [4:0] op);
    case (op)
      5'b00110, 5'b00111, 5'b01001, 5'b01110,
      5'b01111, 5'b10000, 5'b10001, 5'b10010: is_branch = 1'b1;
      default:                                is_branch = 1'b0;
    endcase
  endfunction

  // alu_op_q is stable from issue to capture, so it selects the settle length.
  assign fast_op = !is_branch(alu_op_q);
  assign capture = (state == S_WAIT) && (fast_op ? (cnt == 4'd1) : (cnt == 4'd0));
`else
  assign fast_op = 1'b0;
  assign capture = (state == S_WAIT) && (cnt == 4'd0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      cnt            <= 4'd0;
      last_grant     <= 1'b1;
      alu_a_q        <= 32'd0;
      alu_b_q        <= 32'd0;
      alu_pc_q       <= 32'd0;
      alu_op_q       <= 5'd0;
      rsp_id_q       <= 1'b0;
      rsp_result_q   <= 32'd0;
      rsp_zero_q     <= 1'b0;
      rsp_overflow_q <= 1'b0;
      rsp_branch_q   <= 3'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (fire0 || fire1) begin
            alu_a_q    <= fire1 ? bus.req1_a  : bus.req0_a;
            alu_b_q    <= fire1 ? bus.req1_b  : bus.req0_b;
            alu_pc_q   <= fire1 ? bus.req1_pc : bus.req0_pc;
            alu_op_q   <= fire1 ? bus.req1_op : bus.req0_op;
            rsp_id_q   <= fire1;
            last_grant <= fire1;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (bus.flush) begin
            state <= S_IDLE;
          end else begin
            cnt   <= SETTLE;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.flush) begin
            cnt   <= 4'd0;
            state <= S_IDLE;
          end else if (capture) begin
            rsp_result_q   <= bus.alu_result_in;
            rsp_zero_q     <= bus.alu_zero_in;
            rsp_overflow_q <= bus.alu_overflow_in;
            rsp_branch_q   <= fast_op ? 3'd0 : bus.alu_branch_in;
            cnt            <= 4'd0;
            state          <= S_RESP;
          end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          // A flush alongside rsp_ready still counts as a dropped response.
          if (bus.flush || bus.rsp_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.req0_ready   = ready0;
  assign bus.req1_ready   = ready1;
  assign bus.alu_a        = alu_a_q;
  assign bus.alu_b        = alu_b_q;
  assign bus.alu_pc       = alu_pc_q;
  assign bus.alu_op       = alu_op_q;
  assign bus.alu_tick     = (state == S_ISSUE);
  assign bus.rsp_valid    = (state == S_RESP);
  assign bus.rsp_id       = rsp_id_q;
  assign bus.rsp_result   = rsp_result_q;
  assign bus.rsp_zero     = rsp_zero_q;
  assign bus.rsp_overflow = rsp_overflow_q;
  assign bus.rsp_branch   = rsp_branch_q;
  assign bus.busy         = (state != S_IDLE);

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb/tb_alu_seq_ctrl.sv - directed table-driven bench for alu_seq_ctrl
module tb_alu_seq_ctrl;
  localparam int SETTLE = 3;
`ifdef ALU_SEQ_FASTPATH_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_SUB = 5'b00001;
  localparam logic [4:0] OP_XOR = 5'b00100;
  localparam logic [4:0] OP_BEQ = 5'b01110;
  localparam logic [4:0] OP_BNE = 5'b01111;
  localparam logic [4:0] OP_BLT = 5'b10000;

  logic clk = 1'b0;
  logic rst = 1'b1;

  alu_seq_ctrl_if bus();

  alu_seq_ctrl #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Registered ALU model: loads on tick, outputs garbage until settled.
  logic [31:0] m_a, m_b, m_res, r_res;
  logic [4:0]  m_op;
  int          m_cnt;
  logic        m_ovf, m_ok;
  logic [2:0]  m_br;

  function automatic bit br_op(input logic [4:0] op);
    case (op)
      5'b00110, 5'b00111, 5'b01001, 5'b01110,
      5'b01111, 5'b10000, 5'b10001, 5'b10010: br_op = 1'b1;
      default:                                br_op = 1'b0;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_a <= 0; m_b <= 0; m_op <= 0; m_cnt <= 0;
    end else if (bus.alu_tick) begin
      m_a <= bus.alu_a; m_b <= bus.alu_b; m_op <= bus.alu_op; m_cnt <= SETTLE;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
    end
  end

  always_comb begin
    m_res = m_a - m_b;
    m_ovf = 1'b0;
    m_br  = 3'd0;
    case (m_op)
      OP_ADD: begin
        m_res = m_a + m_b;
        m_ovf = (m_a[31] == m_b[31]) && (m_res[31] != m_a[31]);
      end
      OP_XOR: m_res = m_a ^ m_b;
      default: begin
        m_res = m_a - m_b;
        m_ovf = (m_a[31] != m_b[31]) && (m_res[31] != m_a[31]);
      end
    endcase
    case (m_op)
      OP_BEQ:  m_br = {2'b00, m_a == m_b};
      OP_BNE:  m_br = {2'b00, m_a != m_b};
      OP_BLT:  m_br = {2'b00, $signed(m_a) < $signed(m_b)};
      default: m_br = 3'd0;
    endcase
    m_ok = (m_cnt == 0) || (FAST && m_cnt == 1 && !br_op(m_op));
  end

  assign bus.alu_result_in   = m_ok ? m_res : 32'hDEADBEEF;
  assign bus.alu_zero_in     = m_ok ? (m_res == 32'd0) : (m_res != 32'd0);
  assign bus.alu_overflow_in = m_ok ? m_ovf : !m_ovf;
  assign bus.alu_branch_in   = m_ok ? m_br : 3'b101;

  int tick_total = 0;
  always @(negedge clk) if (bus.alu_tick) tick_total++;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_req(input bit port, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] op, input logic [31:0] pc);
    if (!port) begin
      bus.req0_a = a; bus.req0_b = b; bus.req0_op = op; bus.req0_pc = pc; bus.req0_valid = 1'b1;
    end else begin
      bus.req1_a = a; bus.req1_b = b; bus.req1_op = op; bus.req1_pc = pc; bus.req1_valid = 1'b1;
    end
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic accept(input bit port, input string name);
    int n;
    n = 0;
    #1;
    while (!(port ? bus.req1_ready : bus.req0_ready) && n < 40) begin
      @(negedge clk); #1; n++;
    end
    check({name, " accept"}, 32'(n < 40), 32'd1);
    @(posedge clk);
    @(negedge clk);
    if (!port) bus.req0_valid = 1'b0; else bus.req1_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    do begin
      @(posedge clk); @(negedge clk); lat++;
    end while (!bus.rsp_valid && lat < 40);
  endtask

  task automatic consume();
    @(posedge clk); @(negedge clk); #1;
  endtask

  typedef struct {
    bit          port;
    logic [31:0] a, b;
    logic [4:0]  op;
    logic [31:0] pc;
    logic [31:0] res;
    bit          zero, ovf;
    logic [2:0]  br;
    bit          is_br;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, n, t0;
    vecs[0] = '{0, 32'd5,          32'd7,      OP_ADD, 32'h100, 32'd12,         0, 0, 3'd0, 0};
    vecs[1] = '{1, 32'h1234,       32'h1234,   OP_BEQ, 32'h104, 32'd0,          1, 0, 3'd1, 1};
    vecs[2] = '{1, 32'h1234,       32'h1234,   OP_BNE, 32'h108, 32'd0,          1, 0, 3'd0, 1};
    vecs[3] = '{0, 32'd1,          32'd2,      OP_BLT, 32'h10C, 32'hFFFFFFFF,   0, 0, 3'd1, 1};
    vecs[4] = '{0, 32'h7FFFFFFF,   32'd1,      OP_ADD, 32'h110, 32'h80000000,   0, 1, 3'd0, 0};
    vecs[5] = '{1, 32'd3,          32'd3,      OP_SUB, 32'h114, 32'd0,          1, 0, 3'd0, 0};
    vecs[6] = '{0, 32'd3,          32'd4,      OP_ADD, 32'h118, 32'd7,          0, 0, 3'd0, 0};

    bus.req0_valid = 0; bus.req0_a = 0; bus.req0_b = 0; bus.req0_op = 0; bus.req0_pc = 0;
    bus.req1_valid = 0; bus.req1_a = 0; bus.req1_b = 0; bus.req1_op = 0; bus.req1_pc = 0;
    bus.flush = 0; bus.rsp_ready = 1;

    // Reset state, with a request already presented.
    bus.req0_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("rst req0_ready", 32'(bus.req0_ready), 32'd0);
    check("rst busy",       32'(bus.busy),       32'd0);
    check("rst rsp_valid",  32'(bus.rsp_valid),  32'd0);
    check("rst alu_tick",   32'(bus.alu_tick),   32'd0);
    check("rst alu_a",      bus.alu_a,           32'd0);
    check("rst rsp_result", bus.rsp_result,      32'd0);
    rst = 1'b0;
    bus.req0_valid = 1'b0;

    // Contention from reset: port 0 first, then port 1.
    @(negedge clk);
    drive_req(0, 32'd9, 32'd4, OP_SUB, 32'h200);
    drive_req(1, 32'hF0, 32'hFF, OP_XOR, 32'h300);
    #1;
    check("c1 req0_ready", 32'(bus.req0_ready), 32'd1);
    check("c1 req1_ready", 32'(bus.req1_ready), 32'd0);
    accept(0, "c1");
    #1;
    check("c1 req1 held off", 32'(bus.req1_ready), 32'd0);
    wait_rsp(lat);
    check("c1 latency", 32'(lat), 32'(SETTLE + 2));
    check("c1 result", bus.rsp_result, 32'd5);
    check("c1 id", 32'(bus.rsp_id), 32'd0);
    consume();
    check("c1 req1_ready after", 32'(bus.req1_ready), 32'd1);
    @(negedge clk);
    accept(1, "c2");
    wait_rsp(lat);
    check("c2 result", bus.rsp_result, 32'h0F);
    check("c2 id", 32'(bus.rsp_id), 32'd1);
    consume();
    drive_req(0, 32'd1, 32'd1, OP_ADD, 32'h204);
    accept(0, "solo0");
    wait_rsp(lat);
    check("solo0 id", 32'(bus.rsp_id), 32'd0);
    consume();
    drive_req(0, 32'd2, 32'd2, OP_ADD, 32'h208);
    drive_req(1, 32'd1, 32'd1, OP_SUB, 32'h304);
    #1;
    check("c3 req1_ready", 32'(bus.req1_ready), 32'd1);
    check("c3 req0_ready", 32'(bus.req0_ready), 32'd0);
    accept(1, "c3");
    wait_rsp(lat);
    check("c3 id", 32'(bus.rsp_id), 32'd1);
    consume();
    accept(0, "c4");
    wait_rsp(lat);
    check("c4 id", 32'(bus.rsp_id), 32'd0);
    check("c4 result", bus.rsp_result, 32'd4);
    consume();

    // Table of single-port operations.
    for (int i = 0; i < 7; i++) begin
      int exp_lat;
      t0 = tick_total;
      drive_req(vecs[i].port, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].pc);
      accept(vecs[i].port, $sformatf("v%0d", i));
      check($sformatf("v%0d alu_pc", i), bus.alu_pc, vecs[i].pc);
      check($sformatf("v%0d alu_op", i), 32'(bus.alu_op), 32'(vecs[i].op));
      wait_rsp(lat);
      exp_lat = (FAST && !vecs[i].is_br) ? SETTLE + 1 : SETTLE + 2;
      check($sformatf("v%0d latency", i),  32'(lat),              32'(exp_lat));
      check($sformatf("v%0d result", i),   bus.rsp_result,        vecs[i].res);
      check($sformatf("v%0d zero", i),     32'(bus.rsp_zero),     32'(vecs[i].zero));
      check($sformatf("v%0d overflow", i), 32'(bus.rsp_overflow), 32'(vecs[i].ovf));
      check($sformatf("v%0d branch", i),   32'(bus.rsp_branch),   32'(vecs[i].br));
      check($sformatf("v%0d id", i),       32'(bus.rsp_id),       32'(vecs[i].port));
      consume();
      check($sformatf("v%0d busy after", i), 32'(bus.busy), 32'd0);
      check($sformatf("v%0d ticks", i), 32'(tick_total - t0), 32'd1);
      @(negedge clk);
    end

    // Backpressure: response held 10 cycles, no new accepts meanwhile.
    bus.rsp_ready = 1'b0;
    drive_req(0, 32'd10, 32'd20, OP_ADD, 32'h400);
    accept(0, "bp");
    wait_rsp(lat);
    r_res = bus.rsp_result;
    check("bp result", r_res, 32'd30);
    drive_req(1, 32'd1, 32'd3, OP_XOR, 32'h500);
    n = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); @(negedge clk); #1;
      if (bus.rsp_valid && bus.rsp_result == r_res && bus.rsp_id == 1'b0 &&
          !bus.req0_ready && !bus.req1_ready && bus.busy) n++;
    end
    check("bp stable cycles", 32'(n), 32'd10);
    bus.rsp_ready = 1'b1;
    consume();
    check("bp busy after", 32'(bus.busy), 32'd0);
    check("bp rsp_valid after", 32'(bus.rsp_valid), 32'd0);
    check("bp req1_ready after", 32'(bus.req1_ready), 32'd1);
    @(negedge clk);
    accept(1, "bp1");
    wait_rsp(lat);
    check("bp1 result", bus.rsp_result, 32'd2);
    check("bp1 id", 32'(bus.rsp_id), 32'd1);
    consume();

    // Flush during WAIT.
    drive_req(0, 32'd2, 32'd2, OP_ADD, 32'h600);
    accept(0, "fl");
    @(posedge clk); @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.flush = 1'b0;
    #1;
    check("fl busy", 32'(bus.busy), 32'd0);
    n = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); @(negedge clk);
      if (bus.rsp_valid) n++;
    end
    check("fl no response", 32'(n), 32'd0);
    drive_req(0, 32'd6, 32'd6, OP_ADD, 32'h604);
    accept(0, "fl2");
    wait_rsp(lat);
    check("fl2 latency", 32'(lat), 32'(FAST ? SETTLE + 1 : SETTLE + 2));
    check("fl2 result", bus.rsp_result, 32'd12);
    consume();

    // Flush and rsp_ready together in RESP drop the response.
    bus.rsp_ready = 1'b0;
    drive_req(1, 32'd5, 32'd1, OP_SUB, 32'h700);
    accept(1, "fr");
    wait_rsp(lat);
    bus.flush = 1'b1;
    bus.rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.flush = 1'b0;
    #1;
    check("fr rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("fr busy", 32'(bus.busy), 32'd0);

    // Reset pulsed mid-WAIT.
    @(negedge clk);
    drive_req(0, 32'd8, 32'd8, OP_ADD, 32'h800);
    accept(0, "rw");
    @(posedge clk); @(negedge clk);
    drive_req(1, 32'd1, 32'd1, OP_ADD, 32'h900);
    rst = 1'b1;
    #1;
    check("rw busy",       32'(bus.busy),       32'd0);
    check("rw alu_tick",   32'(bus.alu_tick),   32'd0);
    check("rw alu_a",      bus.alu_a,           32'd0);
    check("rw alu_op",     32'(bus.alu_op),     32'd0);
    check("rw rsp_result", bus.rsp_result,      32'd0);
    check("rw rsp_valid",  32'(bus.rsp_valid),  32'd0);
    check("rw req1_ready", 32'(bus.req1_ready), 32'd0);
    @(posedge clk); @(negedge clk);
    bus.req1_valid = 1'b0;
    rst = 1'b0;
    n = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); @(negedge clk);
      if (bus.rsp_valid || bus.busy) n++;
    end
    check("rw stays idle", 32'(n), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
